// File: rtl/div_pkg.sv
// Shared types and default sizing for the shared iterative divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  localparam int DIV_WIDTH = 6;
  localparam int DIV_NREQ  = 2;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] diff;

  // Borrow out of the single subtractor doubles as the compare result.
  assign t       = {rem_in, bit_in};
  assign diff    = t - {2'b00, b};
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : t[WIDTH:0];
endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin shared restoring divider, one quotient bit per cycle.
// Optional DIV_ZERO_FLAG_EN: short-circuit b==0 and report it on rsp_dz.
module div_share_ctrl import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int NREQ  = DIV_NREQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_q,
  output logic [WIDTH-1:0]         rsp_r
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                     rsp_dz
`endif
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH);

  div_state_t state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt;
  logic             gnt_vld;
  logic             accept;
  logic [WIDTH:0]   rem, rem_nxt;
  logic [WIDTH-1:0] dvd, quo, b_reg;
  logic [CW-1:0]    cnt;
  logic             q_bit;

  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  // Lowest offset from rr_ptr wins, so scan offsets high to low.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_vld) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (gnt_vld) begin
        accept    = 1'b1;
        state_nxt = RUN;
`ifdef DIV_ZERO_FLAG_EN
        if (b_arr[gnt] == '0) state_nxt = DONE;
`endif
      end
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[WIDTH-1]),
    .b       (b_reg),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      rsp_id <= '0;
      rem    <= '0;
      dvd    <= '0;
      quo    <= '0;
      b_reg  <= '0;
      cnt    <= '0;
`ifdef DIV_ZERO_FLAG_EN
      rsp_dz <= 1'b0;
`endif
    end else if (accept) begin
      rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      rsp_id <= gnt;
      b_reg  <= b_arr[gnt];
      dvd    <= a_arr[gnt];
      rem    <= '0;
      quo    <= '0;
      cnt    <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_FLAG_EN
      rsp_dz <= (b_arr[gnt] == '0);
      if (b_arr[gnt] == '0) begin
        quo <= '1;
        rem <= {1'b0, a_arr[gnt]};
      end
`endif
    end else if (state == RUN) begin
      rem <= rem_nxt;
      quo <= {quo[WIDTH-2:0], q_bit};
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      cnt <= cnt - 1'b1;
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_q     = quo;
  assign rsp_r     = rem[WIDTH-1:0];
endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed + random checks of div_share_ctrl with WIDTH=6, NREQ=2.
module tb_div_share_ctrl;
  localparam int W = 6;
  localparam int N = 2;
`ifdef DIV_ZERO_FLAG_EN
  localparam int DZ_LAT = 0;
`else
  localparam int DZ_LAT = 6;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           rsp_id;
  logic [W-1:0]   rsp_q, rsp_r;
`ifdef DIV_ZERO_FLAG_EN
  logic           rsp_dz;
`endif

  int checks = 0;
  int fails  = 0;

  div_share_ctrl #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r)
`ifdef DIV_ZERO_FLAG_EN
    , .rsp_dz(rsp_dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int id, input int a, input int b);
    req_a[id*W +: W] = W'(a);
    req_b[id*W +: W] = W'(b);
  endtask

  // Check the grant, take the accept edge, then apply the post-accept valids.
  task automatic accept_now(input logic [N-1:0] exp_rdy, input logic [N-1:0] after);
    #1 chk("req_ready", req_ready, exp_rdy);
    @(posedge clk); #1;
    req_valid = after;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic check_rsp(input string tag, input int id, input int q, input int r);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_q"}, rsp_q, q);
    chk({tag, "_r"}, rsp_r, r);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int n;
    int id, a, b, d;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_q", rsp_q, 0);
    chk("rst_r", rsp_r, 0);
    chk("rst_ready", req_ready, 0);
`ifdef DIV_ZERO_FLAG_EN
    chk("rst_dz", rsp_dz, 0);
`endif

    // 45/6 on requester 0
    set_op(0, 45, 6);
    req_valid = 2'b01;
    accept_now(2'b01, 2'b00);
    chk("run_ready", req_ready, 0);
    wait_rsp(n);
    chk("lat_45_6", n, 6);
    check_rsp("d45_6", 0, 7, 3);
    finish_rsp();

    // b=1 and a<b on requester 1
    set_op(1, 63, 1);
    req_valid = 2'b10;
    accept_now(2'b10, 2'b00);
    wait_rsp(n);
    check_rsp("d63_1", 1, 63, 0);
    finish_rsp();
    set_op(1, 5, 9);
    req_valid = 2'b10;
    accept_now(2'b10, 2'b00);
    wait_rsp(n);
    check_rsp("d5_9", 1, 0, 5);
    finish_rsp();

    // Both valid twice: 0 then 1 each round
    set_op(0, 10, 3); set_op(1, 20, 4);
    req_valid = 2'b11;
    accept_now(2'b01, 2'b10);
    wait_rsp(n);
    check_rsp("rr1_a", 0, 3, 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    accept_now(2'b10, 2'b00);
    wait_rsp(n);
    check_rsp("rr1_b", 1, 5, 0);
    finish_rsp();
    set_op(0, 50, 7); set_op(1, 33, 5);
    req_valid = 2'b11;
    accept_now(2'b01, 2'b10);
    wait_rsp(n);
    check_rsp("rr2_a", 0, 7, 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    accept_now(2'b10, 2'b00);
    wait_rsp(n);
    check_rsp("rr2_b", 1, 6, 3);
    finish_rsp();

    // Divide by zero
    set_op(0, 17, 0);
    req_valid = 2'b01;
    accept_now(2'b01, 2'b00);
    wait_rsp(n);
    chk("lat_dz", n, DZ_LAT);
    check_rsp("d17_0", 0, 63, 17);
`ifdef DIV_ZERO_FLAG_EN
    chk("dz_flag", rsp_dz, 1);
`endif
    finish_rsp();

    // Backpressure hold in DONE
    set_op(1, 29, 4);
    req_valid = 2'b10;
    accept_now(2'b10, 2'b00);
    wait_rsp(n);
    req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      check_rsp("hold", 1, 7, 1);
      chk("hold_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("release_valid", rsp_valid, 0);
    chk("release_ready", req_ready, 2'b01);
    req_valid = 2'b00;

    // Reset mid-run aborts and clears the pointer
    set_op(0, 45, 6);
    req_valid = 2'b01;
    accept_now(2'b01, 2'b00);
    tick(); tick();
    chk("pre_rst_valid", rsp_valid, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_valid", rsp_valid, 0);
    chk("abort_q", rsp_q, 0);
    chk("abort_id", rsp_id, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) n++;
      tick();
    end
    chk("abort_no_rsp", n, 0);
    set_op(0, 40, 7); set_op(1, 1, 1);
    req_valid = 2'b11;
    accept_now(2'b01, 2'b00);
    wait_rsp(n);
    check_rsp("d40_7", 0, 5, 5);
    finish_rsp();

    // Random traffic with random backpressure
    for (int i = 0; i < 1000; i++) begin
      id = $urandom_range(0, 1);
      a  = $urandom_range(0, 63);
      b  = $urandom_range(1, 63);
      d  = $urandom_range(0, 3);
      set_op(id, a, b);
      req_valid = '0;
      req_valid[id] = 1'b1;
      accept_now(N'(1 << id), 2'b00);
      wait_rsp(n);
      chk("rnd_lat", n, 6);
      for (int k = 0; k < d; k++) tick();
      check_rsp("rnd", id, a / b, a % b);
      finish_rsp();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
